pc_unit: RTL

PC_UNIT -- requirements
Module: pc_unit

---
 rtl/pc_unit.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/pc_unit.sv
`default_nettype none
// ============================================================================
//  Module   : pc_unit
//  Purpose  : Program counter for an in-order fetch stage. It selects the next
//             PC by fixed priority (reset, trap, misaligned redirect, JALR,
//             branch, sequential), supports a RUN/HALT state, and records the
//             trap PC (epc) and the offending misaligned target (bad_addr).
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    DWIDTH    : address width (16..64)
//    RESET_VEC : PC loaded on reset
//    TRAP_VEC  : PC loaded on any trap or misaligned redirect
//  Ports
//    clk, rst          : clock, synchronous active-high reset
//    stall             : hold PC, ignore redirects (traps still taken)
//    fetch_ready       : memory accepts pc_out; enables sequential advance
//    br_taken/br_target: branch or JAL redirect
//    jalr_en/base/off  : JALR redirect, target = (base + off) & ~1
//    trap_req          : exception / interrupt request
//    halt_req, resume  : enter / leave HALT
//    pc_out, pc_plus4  : current PC and its link value
//    fetch_valid       : pc_out is a valid fetch address
//    misalign, bad_addr: one-cycle misaligned-target flag and the target
//    epc               : PC captured on the latest trap
//    halted            : block is in HALT
// ============================================================================
module pc_unit #(
  parameter int                DWIDTH    = 32,
  parameter logic [DWIDTH-1:0] RESET_VEC = '0,
  parameter logic [DWIDTH-1:0] TRAP_VEC  = DWIDTH'(32'h0000_0100)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              fetch_ready,
  input  logic              br_taken,
  input  logic [DWIDTH-1:0] br_target,
  input  logic              jalr_en,
  input  logic [DWIDTH-1:0] jalr_base,
  input  logic [DWIDTH-1:0] jalr_off,
  input  logic              trap_req,
  input  logic              halt_req,
  input  logic              resume,
  output logic [DWIDTH-1:0] pc_out,
  output logic [DWIDTH-1:0] pc_plus4,
  output logic              fetch_valid,
  output logic              misalign,
  output logic [DWIDTH-1:0] bad_addr,
  output logic [DWIDTH-1:0] epc,
  output logic              halted
);

  localparam logic [DWIDTH-1:0] c_STEP    = DWIDTH'(4);
  localparam logic [DWIDTH-1:0] c_LSB_CLR = ~DWIDTH'(1);

  typedef enum logic [0:0] {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DWIDTH-1:0] r_pc, r_epc, r_bad_addr;
  logic [DWIDTH-1:0] w_pc_nxt, w_epc_nxt, w_bad_nxt;
  logic              r_misalign, w_misalign_nxt;

  logic [DWIDTH-1:0] w_jalr_sum, w_jalr_tgt, w_redir_tgt;
  logic              w_redir;

  // JALR wins over a simultaneous branch; the selected target alone decides
  // whether the redirect is misaligned.
  assign w_jalr_sum  = jalr_base + jalr_off;
  assign w_jalr_tgt  = w_jalr_sum & c_LSB_CLR;
  assign w_redir     = jalr_en | br_taken;
  assign w_redir_tgt = jalr_en ? w_jalr_tgt : br_target;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_RUN;
      r_pc       <= RESET_VEC;
      r_epc      <= '0;
      r_bad_addr <= '0;
      r_misalign <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_epc      <= w_epc_nxt;
      r_bad_addr <= w_bad_nxt;
      r_misalign <= w_misalign_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_epc_nxt      = r_epc;
    w_bad_nxt      = r_bad_addr;
    w_misalign_nxt = 1'b0;

    if (trap_req) begin
      // Trap overrides stall, halt_req and redirects, and leaves HALT.
      w_pc_nxt    = TRAP_VEC;
      w_epc_nxt   = r_pc;
      w_state_nxt = S_RUN;
    end else if (r_state == S_RUN) begin
      if (halt_req) begin
        // PC holds on the edge that enters HALT.
        w_state_nxt = S_HALT;
      end else if (!stall) begin
        if (w_redir) begin
          if (w_redir_tgt[1:0] != 2'b00) begin
            w_pc_nxt       = TRAP_VEC;
            w_epc_nxt      = r_pc;
            w_bad_nxt      = w_redir_tgt;
            w_misalign_nxt = 1'b1;
          end else begin
            w_pc_nxt = w_redir_tgt;
          end
        end else if (fetch_ready) begin
          w_pc_nxt = r_pc + c_STEP;
        end
      end
    end else begin
      // HALT: PC holds; resume returns to RUN without moving the PC.
      if (resume) begin
        w_state_nxt = S_RUN;
      end
    end
  end

  assign pc_out      = r_pc;
  assign pc_plus4    = r_pc + c_STEP;
  assign epc         = r_epc;
  assign bad_addr    = r_bad_addr;
  assign misalign    = r_misalign;
  assign halted      = (r_state == S_HALT);
  assign fetch_valid = (r_state == S_RUN) && !r_misalign;

endmodule
`default_nettype wire
